vstu_commit_tracker: RTL and testbench
======================================

# vstu_commit_tracker

Parametrised commit stage for the next-generation vector store unit. It tracks every in-flight vector store from acceptance through W-burst issue to B-response acknowledgment. An instruction retires only when every burst it issued has been answered on the B channel, and SLVERR/DECERR responses are reported instead of dropped. It sits between the store unit's W-beat engine, the AXI B channel and the main sequencer's `pe_resp` path.

## Interface
- `NrVInsn`, 8: number of sequencer instruction IDs; ID width is `idx_width(NrVInsn)`.
- `QueueDepth`, 4: in-flight store instructions; any value ≥1, not limited to powers of two.
- `BurstCntWidth`, 8: width of the per-instruction burst counters.
- `clk_i` in 1: clock.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `insn_valid_i` in 1: new store instruction offered.
- `insn_id_i` in `idx_width(NrVInsn)`: ID of the offered instruction.
- `insn_ready_o` out 1: queue has a free entry.
- `burst_valid_i` in 1: last W beat of one AW burst of the issue-head instruction was sent.
- `burst_ready_o` out 1: the issue-head burst counter can accept another burst.
- `issue_done_i` in 1: pulse, issue head has issued all its bursts; may coincide with `burst_valid_i`.
- `b_valid_i` in 1: B response valid.
- `b_resp_i` in 2: AXI BRESP.
- `b_ready_o` out 1: B response accepted.
- `vinsn_done_o` out `NrVInsn`: one-hot retire pulse, registered.
- `store_error_o` out 1: asserted with a retire pulse when that instruction saw any BRESP ≥ 2.
- `error_id_o` out `idx_width(NrVInsn)`: ID of the erroneous instruction; valid with `store_error_o`.
- `store_pending_o` out 1: queue not empty.
- `store_complete_o` out 1: registered copy of "retire this cycle".

## Operation
- Each entry holds `id`, `issued` counter, `acked` counter, `issue_done` flag and `err` flag.
- Pointers `accept_pnt`, `issue_pnt` and `commit_pnt` each wrap from `QueueDepth-1` to 0. Counts: `issue_cnt` and `commit_cnt`, each `idx_width(QueueDepth)+1` bits.
- Accept: on `insn_valid_i && insn_ready_o`, the entry is cleared and `id` is written; `accept_pnt`, `issue_cnt` and `commit_cnt` are incremented. `insn_ready_o = commit_cnt != QueueDepth`; there is no same-cycle bypass on retire.
- Burst: on `burst_valid_i && burst_ready_o`, `issued` of the issue-pointer entry is incremented. `burst_ready_o = issue_cnt != 0 && issued != 2^BurstCntWidth-1`.
- Issue done: sets `issue_done` of the issue-pointer entry, then advances `issue_pnt` and decrements `issue_cnt`. A burst on the same cycle is counted before the advance. `issue_done_i` while `issue_cnt == 0` is a protocol violation; the bench asserts on it.
- B: `b_ready_o = commit_cnt != 0 && acked < issued` for the commit entry, using registered values. On handshake, `acked` is incremented and `err |= b_resp_i[1]`.
- Retire: when the commit entry has `issue_done` and `acked == issued`, using the values after this cycle's updates:
  - set `vinsn_done_o[id]` next cycle;
  - drive `store_error_o`/`error_id_o` from `err`;
  - advance `commit_pnt`, decrement `commit_cnt`.
- At most one retire per cycle. Zero-burst instructions (`vl=0`) retire on the cycle `issue_done_i` is seen.
- Simultaneous accept and retire leaves `commit_cnt` unchanged. Issue and commit on the same entry in one cycle is legal.

## Timing
- Reset: all pointers, counts and entries are 0. `vinsn_done_o`, `store_error_o`, `error_id_o` and `store_complete_o` reset to 0. `insn_ready_o` resets to 1; `burst_ready_o`, `b_ready_o` and `store_pending_o` reset to 0.
- Reset asserted mid-operation discards all entries with no done pulses.
- Latency: a final B handshake in cycle t gives `vinsn_done_o` high during cycle t+1, for exactly one cycle.
- `insn_ready_o`, `burst_ready_o` and `b_ready_o` depend only on registered state, so there is no combinational path from valid inputs to readies.
- `store_pending_o` is combinational from `commit_cnt`.

## Structure
- `VstuCommitQueueDepth` and the entry struct typedef belong in `ara_pkg`.
- The `vinsn_done` field maps directly into `pe_resp_t`.
- One sub-module, `vstu_burst_counter`: a saturating up-counter with clear, instantiated twice per entry.

## Test plan
- Single instruction, id 3, bursts=2, both B OKAY → `vinsn_done_o=8'b0000_1000`, one cycle after the second B; `store_error_o=0`.
- Four instructions accepted back-to-back with `QueueDepth=4` → `insn_ready_o` low after the 4th; it rises the cycle after the first retire. Pointers wrap, and a 5th instruction retires correctly.
- BRESP=SLVERR on the 2nd of 3 bursts of id 5 → retire pulse with `store_error_o=1` and `error_id_o=5`; the next instruction retires with no error.
- `vl=0` instruction: `issue_done_i` with zero bursts → done pulse the next cycle; `b_ready_o` never asserts for it.
- `BurstCntWidth=2`: 3 bursts issued → `burst_ready_o` drops; one B response does not re-enable it, because it is saturation-limited. Retire occurs after 3 B responses.
- Reset pulse with 2 instructions pending → all outputs return to reset values; no `vinsn_done_o` pulse is emitted.

Source files
------------

// File: rtl/ara_pkg.sv
// rtl/ara_pkg.sv - shared types and helpers for the vector store commit tracker
package ara_pkg;

    // Default number of in-flight vector stores tracked by the commit stage
    localparam int unsigned VstuCommitQueueDepth = 4;

    // Index width for a table of num_idx entries; a single entry still needs one bit
    function automatic int unsigned idx_width(input int unsigned num_idx);
        return (num_idx > 1) ? $clog2(num_idx) : 1;
    endfunction

    // Per-entry status flags; the ID and burst counters sit beside this struct
    // because their widths are set by module parameters
    typedef struct packed {
        logic issue_done;
        logic err;
    } vstu_commit_entry_t;

endpackage

// File: rtl/vstu_burst_counter.sv
// rtl/vstu_burst_counter.sv - saturating up-counter with synchronous clear
module vstu_burst_counter #(
    parameter int unsigned Width = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [Width-1:0] cnt_o
);

    // Clear wins over increment; the count holds at all-ones instead of wrapping
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_o <= '0;
        end else if (clr_i) begin
            cnt_o <= '0;
        end else if (inc_i && (cnt_o != '1)) begin
            cnt_o <= cnt_o + Width'(1);
        end
    end

endmodule

// File: rtl/vstu_commit_tracker.sv
// rtl/vstu_commit_tracker.sv - in-order commit tracking of vector stores against AXI B responses
module vstu_commit_tracker
    import ara_pkg::*;
#(
    parameter int unsigned NrVInsn       = 8,
    parameter int unsigned QueueDepth    = VstuCommitQueueDepth,
    parameter int unsigned BurstCntWidth = 8,
    localparam int unsigned IdW          = idx_width(NrVInsn)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               insn_valid_i,
    input  logic [IdW-1:0]     insn_id_i,
    output logic               insn_ready_o,
    input  logic               burst_valid_i,
    output logic               burst_ready_o,
    input  logic               issue_done_i,
    input  logic               b_valid_i,
    input  logic [1:0]         b_resp_i,
    output logic               b_ready_o,
    output logic [NrVInsn-1:0] vinsn_done_o,
    output logic               store_error_o,
    output logic [IdW-1:0]     error_id_o,
    output logic               store_pending_o,
    output logic               store_complete_o
);

    localparam int unsigned          PtrW     = idx_width(QueueDepth);
    localparam int unsigned          CntW     = PtrW + 1;
    localparam logic [CntW-1:0]      DepthCnt = CntW'(QueueDepth);
    localparam logic [PtrW-1:0]      LastPnt  = PtrW'(QueueDepth - 1);
    localparam logic [BurstCntWidth-1:0] BurstMax = '1;

    vstu_commit_entry_t       entries_q [QueueDepth];
    logic [IdW-1:0]           ids_q     [QueueDepth];
    logic [BurstCntWidth-1:0] issued_cnt[QueueDepth];
    logic [BurstCntWidth-1:0] acked_cnt [QueueDepth];

    logic [PtrW-1:0] accept_pnt_q, issue_pnt_q, commit_pnt_q;
    logic [CntW-1:0] issue_cnt_q, commit_cnt_q;

    logic                     accept, burst_fire, issue_fire, b_fire;
    logic                     same_entry, retire;
    logic                     commit_done, commit_err;
    logic [BurstCntWidth-1:0] commit_issued, commit_acked;
    logic [IdW-1:0]           commit_id;
    logic [NrVInsn-1:0]       retire_onehot;
    logic [QueueDepth-1:0]    entry_clr, issued_inc, acked_inc;

    function automatic logic [PtrW-1:0] wrap_inc(input logic [PtrW-1:0] pnt);
        return (pnt == LastPnt) ? '0 : pnt + PtrW'(1);
    endfunction

    // Readies look only at registered state so valids never feed back into them
    assign insn_ready_o    = commit_cnt_q != DepthCnt;
    assign burst_ready_o   = (issue_cnt_q != '0) && (issued_cnt[issue_pnt_q] != BurstMax);
    assign b_ready_o       = (commit_cnt_q != '0) &&
                             (acked_cnt[commit_pnt_q] < issued_cnt[commit_pnt_q]);
    assign store_pending_o = commit_cnt_q != '0;

    for (genvar i = 0; i < QueueDepth; i++) begin : gen_cnt
        vstu_burst_counter #(.Width(BurstCntWidth)) i_issued (
            .clk_i  (clk_i),
            .rst_ni (rst_ni),
            .clr_i  (entry_clr[i]),
            .inc_i  (issued_inc[i]),
            .cnt_o  (issued_cnt[i])
        );
        vstu_burst_counter #(.Width(BurstCntWidth)) i_acked (
            .clk_i  (clk_i),
            .rst_ni (rst_ni),
            .clr_i  (entry_clr[i]),
            .inc_i  (acked_inc[i]),
            .cnt_o  (acked_cnt[i])
        );
    end

    // Handshakes, counter strobes and the retire decision on post-update commit-entry values
    always_comb begin
        accept     = insn_valid_i && insn_ready_o;
        burst_fire = burst_valid_i && burst_ready_o;
        issue_fire = issue_done_i && (issue_cnt_q != '0);
        b_fire     = b_valid_i && b_ready_o;

        entry_clr  = '0;
        issued_inc = '0;
        acked_inc  = '0;
        entry_clr[accept_pnt_q]  = accept;
        issued_inc[issue_pnt_q]  = burst_fire;
        acked_inc[commit_pnt_q]  = b_fire;

        // The issue head is the commit entry exactly when nothing older is still awaiting B
        same_entry    = (issue_cnt_q != '0) && (issue_pnt_q == commit_pnt_q);
        commit_issued = issued_cnt[commit_pnt_q] + BurstCntWidth'(burst_fire && same_entry);
        commit_acked  = acked_cnt[commit_pnt_q] + BurstCntWidth'(b_fire);
        commit_done   = entries_q[commit_pnt_q].issue_done || (issue_fire && same_entry);
        commit_err    = entries_q[commit_pnt_q].err || (b_fire && b_resp_i[1]);
        retire        = (commit_cnt_q != '0) && commit_done && (commit_acked == commit_issued);

        commit_id     = ids_q[commit_pnt_q];
        retire_onehot = '0;
        retire_onehot[commit_id] = 1'b1;
    end

    // Queue bookkeeping plus the registered retire/error report
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < QueueDepth; i++) begin
                entries_q[i] <= '0;
                ids_q[i]     <= '0;
            end
            accept_pnt_q     <= '0;
            issue_pnt_q      <= '0;
            commit_pnt_q     <= '0;
            issue_cnt_q      <= '0;
            commit_cnt_q     <= '0;
            vinsn_done_o     <= '0;
            store_error_o    <= 1'b0;
            error_id_o       <= '0;
            store_complete_o <= 1'b0;
        end else begin
            // The accepted slot is always free, so it never collides with issue/commit writes
            if (accept) begin
                entries_q[accept_pnt_q] <= '0;
                ids_q[accept_pnt_q]     <= insn_id_i;
                accept_pnt_q            <= wrap_inc(accept_pnt_q);
            end
            if (issue_fire) begin
                entries_q[issue_pnt_q].issue_done <= 1'b1;
                issue_pnt_q                       <= wrap_inc(issue_pnt_q);
            end
            if (b_fire && b_resp_i[1]) begin
                entries_q[commit_pnt_q].err <= 1'b1;
            end
            if (retire) begin
                commit_pnt_q <= wrap_inc(commit_pnt_q);
            end
            issue_cnt_q  <= issue_cnt_q + CntW'(accept) - CntW'(issue_fire);
            commit_cnt_q <= commit_cnt_q + CntW'(accept) - CntW'(retire);

            vinsn_done_o     <= retire ? retire_onehot : '0;
            store_complete_o <= retire;
            store_error_o    <= retire && commit_err;
            error_id_o       <= (retire && commit_err) ? commit_id : '0;
        end
    end

endmodule

// File: tb/tb_vstu_commit_tracker.sv
// tb/tb_vstu_commit_tracker.sv - scoreboard bench for vstu_commit_tracker
module tb_vstu_commit_tracker;

    localparam int NRV   = 8;
    localparam int DEPTH = 4;
    localparam int BW    = 2;
    localparam int BMAX  = (1 << BW) - 1;

    logic           clk_i = 1'b0;
    logic           rst_ni = 1'b0;
    logic           insn_valid_i = 1'b0;
    logic [2:0]     insn_id_i = '0;
    logic           insn_ready_o;
    logic           burst_valid_i = 1'b0;
    logic           burst_ready_o;
    logic           issue_done_i = 1'b0;
    logic           b_valid_i = 1'b0;
    logic [1:0]     b_resp_i = '0;
    logic           b_ready_o;
    logic [NRV-1:0] vinsn_done_o;
    logic           store_error_o;
    logic [2:0]     error_id_o;
    logic           store_pending_o;
    logic           store_complete_o;

    vstu_commit_tracker #(
        .NrVInsn       (NRV),
        .QueueDepth    (DEPTH),
        .BurstCntWidth (BW)
    ) dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .insn_valid_i     (insn_valid_i),
        .insn_id_i        (insn_id_i),
        .insn_ready_o     (insn_ready_o),
        .burst_valid_i    (burst_valid_i),
        .burst_ready_o    (burst_ready_o),
        .issue_done_i     (issue_done_i),
        .b_valid_i        (b_valid_i),
        .b_resp_i         (b_resp_i),
        .b_ready_o        (b_ready_o),
        .vinsn_done_o     (vinsn_done_o),
        .store_error_o    (store_error_o),
        .error_id_o       (error_id_o),
        .store_pending_o  (store_pending_o),
        .store_complete_o (store_complete_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int id;
        int issued;
        int acked;
        bit idone;
        bit err;
    } ent_t;

    typedef struct {
        int id;
        bit err;
        int due;
    } exp_t;

    ent_t m_q[$];
    exp_t exp_q[$];
    int   m_hi = 0;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, expv);
        end
    endtask

    function automatic bit m_insn_rdy();
        return m_q.size() < DEPTH;
    endfunction

    function automatic bit m_burst_rdy();
        return (m_hi < m_q.size()) && (m_q[m_hi].issued < BMAX);
    endfunction

    function automatic bit m_b_rdy();
        return (m_q.size() > 0) && (m_q[0].acked < m_q[0].issued);
    endfunction

    task automatic chk_reset_vals();
        chk("rst_vinsn_done", vinsn_done_o, 0);
        chk("rst_store_error", store_error_o, 0);
        chk("rst_error_id", error_id_o, 0);
        chk("rst_store_complete", store_complete_o, 0);
        chk("rst_insn_ready", insn_ready_o, 1);
        chk("rst_burst_ready", burst_ready_o, 0);
        chk("rst_b_ready", b_ready_o, 0);
        chk("rst_store_pending", store_pending_o, 0);
    endtask

    // One clock of stimulus: check readies against the model, drive, advance the model
    task automatic cycle(input bit iv, input int iid, input bit bv, input bit idn,
                         input bit bvl, input logic [1:0] br);
        bit   acc, bst, bf;
        ent_t e;
        exp_t x;
        chk("insn_ready", insn_ready_o, m_insn_rdy());
        chk("burst_ready", burst_ready_o, m_burst_rdy());
        chk("b_ready", b_ready_o, m_b_rdy());
        chk("store_pending", store_pending_o, m_q.size() != 0);
        assert (!(idn && (m_hi >= m_q.size()))) else $error("issue_done with no issue head");
        acc = iv && m_insn_rdy();
        bst = bv && m_burst_rdy();
        bf  = bvl && m_b_rdy();
        insn_valid_i  = iv;
        insn_id_i     = 3'(iid);
        burst_valid_i = bv;
        issue_done_i  = idn;
        b_valid_i     = bvl;
        b_resp_i      = br;
        if (bst) m_q[m_hi].issued = m_q[m_hi].issued + 1;
        if (idn) begin
            m_q[m_hi].idone = 1'b1;
            m_hi++;
        end
        if (bf) begin
            m_q[0].acked = m_q[0].acked + 1;
            if (br >= 2) m_q[0].err = 1'b1;
        end
        if (m_q.size() > 0 && m_q[0].idone && m_q[0].acked == m_q[0].issued) begin
            x.id  = m_q[0].id;
            x.err = m_q[0].err;
            x.due = cyc + 1;
            exp_q.push_back(x);
            void'(m_q.pop_front());
            m_hi--;
        end
        if (acc) begin
            e.id = iid; e.issued = 0; e.acked = 0; e.idone = 1'b0; e.err = 1'b0;
            m_q.push_back(e);
        end
        @(negedge clk_i);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 2'd0);
    endtask

    task automatic do_reset(input int n);
        rst_ni = 1'b0;
        insn_valid_i = 1'b0; burst_valid_i = 1'b0; issue_done_i = 1'b0; b_valid_i = 1'b0;
        m_q.delete();
        m_hi = 0;
        repeat (n) @(negedge clk_i);
        chk_reset_vals();
        rst_ni = 1'b1;
    endtask

    // Monitor: every retire pulse must match the oldest expected retirement, on its due cycle
    initial begin
        exp_t x;
        forever begin
            @(posedge clk_i);
            #1;
            if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                x = exp_q.pop_front();
                chk("vinsn_done", vinsn_done_o, 32'(1) << x.id);
                chk("store_complete", store_complete_o, 1);
                chk("store_error", store_error_o, x.err);
                if (x.err) chk("error_id", error_id_o, x.id);
            end else begin
                chk("no_spurious_done", vinsn_done_o, 0);
                chk("no_spurious_complete", store_complete_o, 0);
                chk("no_spurious_error", store_error_o, 0);
            end
        end
    end

    initial begin
        int n;
        @(negedge clk_i);
        do_reset(3);

        // id 3, two bursts, both OKAY
        cycle(1, 3, 0, 0, 0, 2'd0);
        cycle(0, 0, 1, 0, 0, 2'd0);
        cycle(0, 0, 1, 1, 0, 2'd0);
        cycle(0, 0, 0, 0, 1, 2'd0);
        cycle(0, 0, 0, 0, 1, 2'd0);
        idle(2);

        // Fill the queue, reject a 5th, then wrap around
        cycle(1, 0, 0, 0, 0, 2'd0);
        cycle(1, 1, 0, 0, 0, 2'd0);
        cycle(1, 2, 0, 0, 0, 2'd0);
        cycle(1, 4, 0, 0, 0, 2'd0);
        cycle(1, 6, 0, 1, 0, 2'd0);
        cycle(1, 7, 0, 1, 0, 2'd0);
        cycle(0, 0, 0, 1, 0, 2'd0);
        cycle(0, 0, 0, 1, 0, 2'd0);
        cycle(0, 0, 0, 1, 0, 2'd0);
        idle(2);

        // SLVERR on the 2nd of 3 bursts of id 5, then a clean id 6
        cycle(1, 5, 0, 0, 0, 2'd0);
        cycle(1, 6, 1, 0, 0, 2'd0);
        cycle(0, 0, 1, 0, 1, 2'd0);
        cycle(0, 0, 1, 1, 1, 2'd2);
        cycle(0, 0, 0, 0, 1, 2'd0);
        cycle(0, 0, 1, 0, 0, 2'd0);
        cycle(0, 0, 0, 1, 1, 2'd0);
        idle(2);

        // Zero-burst instruction
        cycle(1, 2, 0, 0, 0, 2'd0);
        cycle(0, 0, 0, 1, 1, 2'd0);
        idle(2);

        // Burst counter saturation at 3
        cycle(1, 1, 0, 0, 0, 2'd0);
        cycle(0, 0, 1, 0, 0, 2'd0);
        cycle(0, 0, 1, 0, 0, 2'd0);
        cycle(0, 0, 1, 0, 0, 2'd0);
        cycle(0, 0, 1, 0, 0, 2'd0);
        cycle(0, 0, 1, 0, 1, 2'd0);
        cycle(0, 0, 1, 0, 0, 2'd0);
        cycle(0, 0, 0, 1, 1, 2'd0);
        cycle(0, 0, 0, 0, 1, 2'd3);
        idle(2);

        // Reset with two instructions pending
        cycle(1, 1, 0, 0, 0, 2'd0);
        cycle(1, 2, 1, 0, 0, 2'd0);
        cycle(0, 0, 1, 0, 1, 2'd0);
        do_reset(2);
        idle(3);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom % 3) == 0, $urandom_range(0, 7), $urandom % 2,
                  (m_hi < m_q.size()) && (($urandom % 4) == 0),
                  ($urandom % 3) != 0,
                  (($urandom % 5) == 0) ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1)));
        end

        // Drain with a bounded cycle budget
        n = 0;
        while (m_q.size() > 0 && n < 500) begin
            cycle(0, 0, 0, m_hi < m_q.size(), 1, 2'd0);
            n++;
        end
        n_tests++;
        if (m_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain_timeout: %0d entries left, required 0", m_q.size());
        end
        idle(3);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL retire_missing: %0d expected retirements unseen, required 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
